// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the hazard tracker: the opcode and function
// encodings of the 16-bit CPU, forwarding encodings, the link register
// number and the record formats passed between decode and tracking logic.
package hazard_tracker_pkg;

  localparam int WORD_SIZE = 16;

  // Major opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RRR = 4'd15;

  // RRR function codes, instruction bits [5:0]
  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  // Forward select value meaning "read the register file"
  localparam int FWD_RF = 0;

  // Register written by JAL and JRL with the return address
  localparam logic [1:0] LINK_REG = 2'd2;

  // One in-flight destination write per tracked stage
  typedef struct packed {
    logic       valid;
    logic [1:0] dest;
    logic       is_load;
  } entry_t;

  // Decoded view of the instruction in ID
  typedef struct packed {
    logic       writes;
    logic [1:0] dest;
    logic       is_load;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] rs;
    logic [1:0] rt;
  } decode_t;

  // True when a tracked entry will write the given register
  function automatic logic reg_match(input entry_t e, input logic [1:0] r);
    return e.valid && (e.dest == r);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the ID instruction into the destination it will
// write (if any) and the source registers it actually reads.
module hazard_decode
  import hazard_tracker_pkg::*;
(
  input  logic [WORD_SIZE-1:0] id_instr,
  output decode_t              dec
);

  logic [3:0] op_s;
  logic [5:0] func_s;

  assign op_s   = id_instr[15:12];
  assign func_s = id_instr[5:0];

  // Classify the instruction: destination, load flag and used sources
  always_comb begin
    dec        = '0;
    dec.rs     = id_instr[11:10];
    dec.rt     = id_instr[9:8];
    case (op_s)
      OP_RRR: begin
        dec.use_rs = (func_s != FUNC_HLT);
        case (func_s)
          FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR: dec.use_rt = 1'b1;
          default:                                dec.use_rt = 1'b0;
        endcase
        case (func_s)
          FUNC_WWD, FUNC_JPR, FUNC_HLT: begin
            dec.writes = 1'b0;
            dec.dest   = 2'd0;
          end
          FUNC_JRL: begin
            dec.writes = 1'b1;
            dec.dest   = LINK_REG;
          end
          default: begin
            dec.writes = 1'b1;
            dec.dest   = id_instr[7:6];
          end
        endcase
      end
      OP_ADI, OP_ORI: begin
        dec.writes = 1'b1;
        dec.dest   = id_instr[9:8];
        dec.use_rs = 1'b1;
      end
      OP_LHI: begin
        dec.writes = 1'b1;
        dec.dest   = id_instr[9:8];
      end
      OP_LWD: begin
        dec.writes  = 1'b1;
        dec.dest    = id_instr[9:8];
        dec.is_load = 1'b1;
        dec.use_rs  = 1'b1;
      end
      OP_SWD, OP_BNE, OP_BEQ: begin
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
      end
      OP_BGZ, OP_BLZ: begin
        dec.use_rs = 1'b1;
      end
      OP_JAL: begin
        dec.writes = 1'b1;
        dec.dest   = LINK_REG;
      end
      OP_JMP: begin
        dec.writes = 1'b0;
      end
      default: begin
        dec.writes = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard and forwarding controller. Tracks destination writes of the
// instructions in EX..WB, selects forwarding sources for the ID operands,
// stalls on load-use (or on any dependency when forwarding is disabled)
// and counts stalled cycles with saturation.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WORD_SIZE-1:0]         id_instr,
  input  logic                         id_valid,
  input  logic                         flush,
  output logic                         id_ready,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int FW = $clog2(DEPTH + 1);

  decode_t               dec_s;
  entry_t [DEPTH-1:0]    entry_r;
  entry_t                new_entry_s;
  logic   [DEPTH-1:0]    match_rs_s;
  logic   [DEPTH-1:0]    match_rt_s;
  logic   [FW-1:0]       fwd_rs_s;
  logic   [FW-1:0]       fwd_rt_s;
  logic                  hazard_s;
  logic                  stall_s;
  logic   [CNT_W-1:0]    stall_count_r;

  hazard_decode u_decode (
    .id_instr (id_instr),
    .dec      (dec_s)
  );

  // Per-stage dependency of each used ID source on a tracked write
  always_comb begin
    match_rs_s = '0;
    match_rt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_rs_s[i] = dec_s.use_rs && reg_match(entry_r[i], dec_s.rs);
      match_rt_s[i] = dec_s.use_rt && reg_match(entry_r[i], dec_s.rt);
    end
  end

  // Priority encode: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_rs_s = FW'(FWD_RF);
    fwd_rt_s = FW'(FWD_RF);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fwd_rs_s = match_rs_s[i] ? FW'(i + 1) : fwd_rs_s;
      fwd_rt_s = match_rt_s[i] ? FW'(i + 1) : fwd_rt_s;
    end
  end

  // Stall decision: load in EX with forwarding, any dependency without it
  always_comb begin
    if (FWD_EN != 0) begin
      hazard_s = (match_rs_s[0] || match_rt_s[0]) && entry_r[0].is_load;
    end else begin
      hazard_s = (|match_rs_s) || (|match_rt_s);
    end
    if (id_valid && !flush) begin
      stall_s = hazard_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Forward selects are suppressed while stalled or with forwarding off
  always_comb begin
    if ((FWD_EN != 0) && !stall_s) begin
      fwd_a = fwd_rs_s;
      fwd_b = fwd_rt_s;
    end else begin
      fwd_a = FW'(FWD_RF);
      fwd_b = FW'(FWD_RF);
    end
  end

  // Entry entering EX: the decoded instruction, or a bubble
  always_comb begin
    if (id_valid && !stall_s && !flush) begin
      new_entry_s.valid   = dec_s.writes;
      new_entry_s.dest    = dec_s.dest;
      new_entry_s.is_load = dec_s.is_load;
    end else begin
      new_entry_s = '0;
    end
  end

  // Advance the in-flight write tracking one stage per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_r <= '0;
    end else begin
      entry_r <= {entry_r[DEPTH-2:0], new_entry_s};
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_r <= '0;
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + CNT_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall       = stall_s;
  assign id_ready    = !stall_s;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker. Three instances share one input
// stream: forwarding enabled (DEPTH 3), forwarding disabled (DEPTH 3) and
// forwarding disabled with DEPTH 6 and a 2-bit saturating counter.
module tb_hazard_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        flush;

  logic        rdy0, st0;
  logic [1:0]  fa0, fb0;
  logic [15:0] cnt0;
  logic        rdy1, st1;
  logic [1:0]  fa1, fb1;
  logic [15:0] cnt1;
  logic        rdy2, st2;
  logic [2:0]  fa2, fb2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_tracker #(.DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .flush(flush), .id_ready(rdy0), .stall(st0), .fwd_a(fa0), .fwd_b(fb0),
    .stall_count(cnt0));

  hazard_tracker #(.DEPTH(3), .FWD_EN(0), .CNT_W(16)) u_nofwd (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .flush(flush), .id_ready(rdy1), .stall(st1), .fwd_a(fa1), .fwd_b(fb1),
    .stall_count(cnt1));

  hazard_tracker #(.DEPTH(6), .FWD_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .flush(flush), .id_ready(rdy2), .stall(st2), .fwd_a(fa2), .fwd_b(fb2),
    .stall_count(cnt2));

  typedef struct {
    int          dut;
    logic        stall;
    logic [2:0]  fa;
    logic [2:0]  fb;
    logic        chk_fwd;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic        v;
    logic        f;
    logic        stall;
    logic [2:0]  fa;
    logic [2:0]  fb;
    logic [15:0] cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input int dut,
                     input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, dut, $time, act, req);
    end
  endtask

  task automatic push_exp(input int dut, input logic s, input logic [2:0] fa,
                          input logic [2:0] fb, input logic chk_fwd,
                          input logic [15:0] c);
    exp_t e;
    e.dut = dut; e.stall = s; e.fa = fa; e.fb = fb; e.chk_fwd = chk_fwd; e.cnt = c;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare against the named instance
  task automatic drain();
    exp_t        e;
    logic        a_st, a_rdy;
    logic [2:0]  a_fa, a_fb;
    logic [15:0] a_cnt;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin a_st = st0; a_rdy = rdy0; a_fa = {1'b0, fa0}; a_fb = {1'b0, fb0}; a_cnt = cnt0; end
        1: begin a_st = st1; a_rdy = rdy1; a_fa = {1'b0, fa1}; a_fb = {1'b0, fb1}; a_cnt = cnt1; end
        default: begin a_st = st2; a_rdy = rdy2; a_fa = fa2; a_fb = fb2; a_cnt = {14'd0, cnt2}; end
      endcase
      cmp("stall", e.dut, {15'd0, a_st}, {15'd0, e.stall});
      cmp("id_ready", e.dut, {15'd0, a_rdy}, {15'd0, !e.stall});
      if (e.chk_fwd) begin
        cmp("fwd_a", e.dut, {13'd0, a_fa}, {13'd0, e.fa});
        cmp("fwd_b", e.dut, {13'd0, a_fb}, {13'd0, e.fb});
      end
      cmp("stall_count", e.dut, a_cnt, e.cnt);
    end
  endtask

  // Drive one ID slot, check at the falling edge, then take the rising edge
  task automatic cycle(input logic [15:0] ins, input logic v, input logic f);
    id_instr = ins;
    id_valid = v;
    flush    = f;
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Forwarding instance, run straight after reset release
    tbl[0]  = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0}; // first ADD after reset
    tbl[1]  = '{16'h4105, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0}; // ADI $1,$0,5
    tbl[2]  = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 16'd0}; // ADI in EX
    tbl[3]  = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 16'd0}; // ADI in stage 1
    tbl[4]  = '{16'hFAC0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 16'd0}; // $2 in EX and stage 1
    tbl[5]  = '{16'h7100, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0}; // LWD $1
    tbl[6]  = '{16'hF580, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 16'd0}; // load-use stall
    tbl[7]  = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 16'd1}; // load now in stage 1
    tbl[8]  = '{16'hF45C, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 16'd1}; // WWD $1 reads load in WB
    tbl[9]  = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // WWD wrote nothing
    tbl[10] = '{16'hF05D, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // HLT
    tbl[11] = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // HLT wrote nothing
    tbl[12] = '{16'h7100, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // invalid LWD
    tbl[13] = '{16'hF580, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // no load-use from bubble
    tbl[14] = '{16'hA000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // JAL
    tbl[15] = '{16'hFAC0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 16'd1}; // JAL link $2, younger wins
    tbl[16] = '{16'hF41A, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd1}; // JRL $1
    tbl[17] = '{16'hFAC0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 16'd1}; // JRL link $2

    reset_n  = 1'b0;
    id_instr = 16'hF580;
    id_valid = 1'b1;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with an instruction presented: every instance idle
    for (int d = 0; d < 3; d++) push_exp(d, 1'b0, 3'd0, 3'd0, 1'b1, 16'd0);
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      push_exp(0, tbl[i].stall, tbl[i].fa, tbl[i].fb, 1'b1, tbl[i].cnt);
      cycle(tbl[i].ins, tbl[i].v, tbl[i].f);
    end

    // Flush wins over a load-use hazard and lets a bubble into EX
    push_exp(0, 1'b0, 3'd0, 3'd0, 1'b1, 16'd1);
    cycle(16'h7100, 1'b1, 1'b0);
    push_exp(0, 1'b0, 3'd0, 3'd0, 1'b0, 16'd1);
    cycle(16'hF580, 1'b1, 1'b1);
    push_exp(0, 1'b0, 3'd2, 3'd2, 1'b1, 16'd1);
    cycle(16'hF580, 1'b1, 1'b0);

    // Reset asserted in the middle of a load-use stall
    push_exp(0, 1'b0, 3'd0, 3'd0, 1'b1, 16'd1);
    cycle(16'h7100, 1'b1, 1'b0);
    id_instr = 16'hF580;
    id_valid = 1'b1;
    flush    = 1'b0;
    push_exp(0, 1'b1, 3'd0, 3'd0, 1'b1, 16'd1);
    @(negedge clk);
    drain();
    #1;
    reset_n = 1'b0;
    #1;
    push_exp(0, 1'b0, 3'd0, 3'd0, 1'b1, 16'd0);
    drain();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // No forwarding: ADI then a dependent ADD held in ID
    push_exp(1, 1'b0, 3'd0, 3'd0, 1'b1, 16'd0);
    push_exp(2, 1'b0, 3'd0, 3'd0, 1'b1, 16'd0);
    cycle(16'h4105, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      push_exp(1, (k <= 3), 3'd0, 3'd0, 1'b1, (k - 1 < 3) ? 16'(k - 1) : 16'd3);
      push_exp(2, (k <= 6), 3'd0, 3'd0, 1'b1, (k - 1 < 3) ? 16'(k - 1) : 16'd3);
      cycle(16'hF580, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Parametrised hazard and forwarding controller for the 16-bit pipelined CPU. It decodes the instruction in ID and keeps its own shift register of in-flight destination writes, one entry per stage from EX to WB. From that tracking state it produces per-operand forwarding selects, a load-use or no-forward stall, and a saturating stall counter. It sits between the IF/ID latch and the ID/EX latch and replaces ad-hoc hazard detection that looked only at instruction words.

## Interface
- `DEPTH`, default 3: tracked stages after ID, where stage 0 = EX and stage DEPTH-1 = WB; legal range 2..6.
- `FWD_EN`, default 1: 1 = forward from any tracked stage and stall only on load-use; 0 = stall until the producer has left WB.
- `CNT_W`, default 16: width of `stall_count`.
- `clk` in 1: single clock; all state is on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `id_instr` in `WORD_SIZE`: the instruction currently in ID.
- `id_valid` in 1: `id_instr` is a real instruction, not a bubble.
- `flush` in 1: a control redirect this cycle; the ID instruction is squashed.
- `id_ready` out 1: equals `!stall`; ID may advance.
- `stall` out 1: hold IF/ID and insert a bubble into EX.
- `fwd_a` out `$clog2(DEPTH+1)`: rs source, where 0 = register file and k = result of stage k-1.
- `fwd_b` out `$clog2(DEPTH+1)`: rt source, same encoding as `fwd_a`.
- `stall_count` out `CNT_W`: number of stalled cycles, saturating.

## Operation
- **Decode of destinations** (from `opcodes.v`):
  - RRR writes [7:6], except WWD, JPR and HLT, which write nothing.
  - JRL and JAL write register 2.
  - ADI, ORI, LHI and LWD write [9:8].
  - All other opcodes write nothing. Each entry is also flagged `is_load` for LWD.
- **Decode of sources:**
  - rs = [11:10] is used by RRR (except HLT), ADI, ORI, LWD, SWD and all branches.
  - rt = [9:8] is used by RRR arithmetic/logic, SWD, BNE and BEQ.
  - LHI, JMP and JAL use no sources.
- **Entry format:** {valid, dest[1:0], is_load}. The register file commits when an entry leaves stage DEPTH-1.
- **Match rule:** a used source matches stage i if entry[i] is valid and its dest equals the source. The youngest match (lowest i) wins.
- **Stall, FWD_EN=1:** stall = `id_valid` && !`flush` && a used source matches stage 0 && entry[0].is_load.
- **Stall, FWD_EN=0:** stall = `id_valid` && !`flush` && a used source matches any stage.
- **Forward select:** `fwd_x` = i+1 for the youngest match, or 0 if there is no match, the source is unused, `stall`=1, or FWD_EN=0.
- **Shift each cycle:**
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= decoded ID instruction when `id_valid` && !`stall` && !`flush`; otherwise a bubble (valid=0).
- **Flush:** in the same cycle it also invalidates the incoming entry[0]. Older stages are untouched.
- **Stall counter:** `stall_count` increments on each cycle with `stall`=1 and saturates at all-ones.
- **Reset:** all entries are invalid. `stall`=0, `id_ready`=1, `fwd_a`=`fwd_b`=0, `stall_count`=0.

## Timing
- `stall`, `id_ready` and `fwd_*` are combinational from `id_instr` and the current entries. The datapath latches `fwd_*` into ID/EX on the same edge.
- **Load-use:** exactly 1 stall cycle with FWD_EN=1. On the next cycle the load sits in stage 1, so `fwd` = 2.
- **FWD_EN=0:** a producer in stage i stalls for DEPTH-i cycles.
- **`flush` and hazard together:** `flush` wins. `stall`=0, no count, and a bubble enters.
- **Asserting `reset_n` mid-stall:** outputs go to reset values immediately, without waiting for a clock edge.
- **Matches in two stages:** the younger stage wins. There is no write-back/read conflict at stage DEPTH-1, since that stage is forwarded (FWD_EN=1) or stalls (FWD_EN=0).

## Structure
- **Shared include** `opcodes.v`:
  - holds the opcode and function macros;
  - add the FWD_RF=0 encoding and the JAL/JRL link register constant (2) there.
- **Sub-module** `hazard_decode`:
  - combinational: `id_instr` → {writes, dest, is_load, use_rs, use_rt};
  - instantiated once.
- **Top module:** the entry shift register, match logic, priority encoder and counter stay in the top module.

## Test plan
- **Reset:** drive `reset_n`=0 during activity → all outputs at reset values; after release, the first ADD is issued with `fwd_a`=`fwd_b`=0.
- **Forward from EX:** with FWD_EN=1, ADI $1,$0,5 (0x4105) then ADD $2,$1,$1 (0xF580) → `stall`=0, `fwd_a`=`fwd_b`=1; a second ADD one cycle later → `fwd`=2.
- **Load-use:** with FWD_EN=1, LWD $1 (0x7100) then 0xF580 → `stall`=1 for one cycle, `stall_count`=1, then `fwd_a`=2.
- **No forwarding:** with FWD_EN=0 and DEPTH=3, 0x4105 then 0xF580 → `stall` for 3 cycles, then `fwd`=0, `stall_count`=3.
- **Flush over load-use:** `flush` asserted during the load-use cycle → `stall`=0, the count is unchanged, and the next cycle shows entry[0] invalid (a following 0xF580 gives `fwd`=2 from the load).
- **Counter edge cases:** with CNT_W=2, force 5 stall cycles → `stall_count` saturates at 3. WWD and HLT producers never cause a match.
